// File: rtl/decoder.sv
// Registered triple BCD-to-7-segment decoder for the M:SS microwave timer display.
// Define DECODER_ACTIVE_LOW_SEG_EN to invert every output bit for common-anode digits.
module decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sec_unidades,
  input  logic [3:0] sec_dezenas,
  input  logic [3:0] minutos,
  output logic [6:0] seg_unidades,
  output logic [6:0] seg_dezenas,
  output logic [6:0] seg_minutos
);

`ifdef DECODER_ACTIVE_LOW_SEG_EN
  localparam logic [6:0] POL_MASK = 7'h7F;
`else
  localparam logic [6:0] POL_MASK = 7'h00;
`endif

  // Bit order a..g on [6:0]. Codes 10..15 and X/Z inputs show a lone g segment.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'h7E;
      4'd1:    seg = 7'h30;
      4'd2:    seg = 7'h6D;
      4'd3:    seg = 7'h79;
      4'd4:    seg = 7'h33;
      4'd5:    seg = 7'h5B;
      4'd6:    seg = 7'h5F;
      4'd7:    seg = 7'h70;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h7B;
      default: seg = 7'h01;
    endcase
    return seg;
  endfunction

  logic [6:0] next_unidades_s;
  logic [6:0] next_dezenas_s;
  logic [6:0] next_minutos_s;
  logic [6:0] seg_unidades_r;
  logic [6:0] seg_dezenas_r;
  logic [6:0] seg_minutos_r;

  // Decode each digit and apply the display polarity.
  always_comb begin
    next_unidades_s = bcd_to_seg(sec_unidades) ^ POL_MASK;
    next_dezenas_s  = bcd_to_seg(sec_dezenas)  ^ POL_MASK;
    next_minutos_s  = bcd_to_seg(minutos)      ^ POL_MASK;
  end

  // Output registers; reset blanks all digits and overrides the decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_unidades_r <= POL_MASK;
      seg_dezenas_r  <= POL_MASK;
      seg_minutos_r  <= POL_MASK;
    end else begin
      seg_unidades_r <= next_unidades_s;
      seg_dezenas_r  <= next_dezenas_s;
      seg_minutos_r  <= next_minutos_s;
    end
  end

  assign seg_unidades = seg_unidades_r;
  assign seg_dezenas  = seg_dezenas_r;
  assign seg_minutos  = seg_minutos_r;

endmodule

// File: tb/tb_decoder.sv
// Directed self-checking bench for decoder; expected patterns follow the display polarity macro.
module tb_decoder;

`ifdef DECODER_ACTIVE_LOW_SEG_EN
  localparam logic [6:0] INV = 7'h7F;
`else
  localparam logic [6:0] INV = 7'h00;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sec_unidades = 4'd7;
  logic [3:0] sec_dezenas  = 4'd3;
  logic [3:0] minutos      = 4'd9;
  logic [6:0] seg_unidades;
  logic [6:0] seg_dezenas;
  logic [6:0] seg_minutos;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [6:0] seg_tab [16];

  decoder dut (
    .clk          (clk),
    .rst          (rst),
    .sec_unidades (sec_unidades),
    .sec_dezenas  (sec_dezenas),
    .minutos      (minutos),
    .seg_unidades (seg_unidades),
    .seg_dezenas  (seg_dezenas),
    .seg_minutos  (seg_minutos)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check3(input string name, input logic [6:0] eu, input logic [6:0] ed,
                        input logic [6:0] em);
    total_cnt++;
    if (seg_unidades !== (eu ^ INV) || seg_dezenas !== (ed ^ INV) || seg_minutos !== (em ^ INV))
      $display("FAIL %s: got %h/%h/%h expected %h/%h/%h", name,
               seg_unidades, seg_dezenas, seg_minutos, eu ^ INV, ed ^ INV, em ^ INV);
    else
      pass_cnt++;
  endtask

  task automatic drive(input logic [3:0] u, input logic [3:0] d, input logic [3:0] m);
    sec_unidades = u;
    sec_dezenas  = d;
    minutos      = m;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(4'd7, 4'd3, 4'd9);
    tick();
    tick();
    check3("reset", 7'h00, 7'h00, 7'h00);
  endtask

  task automatic test_digits();
    rst = 1'b0;
    drive(4'd5, 4'd9, 4'd2);
    tick();
    check3("case2_5_9_2", 7'h5B, 7'h7B, 7'h6D);
    drive(4'd8, 4'd1, 4'd0);
    tick();
    check3("case3_8_1_0", 7'h7F, 7'h30, 7'h7E);
    drive(4'd3, 4'd4, 4'd6);
    tick();
    check3("case4_3_4_6", 7'h79, 7'h33, 7'h5F);
    minutos = 4'd7;
    tick();
    check3("case4_min7", 7'h79, 7'h33, 7'h70);
  endtask

  task automatic test_latency();
    drive(4'd1, 4'd1, 4'd1);
    #2;
    check3("latency_hold", 7'h79, 7'h33, 7'h70);
    tick();
    check3("latency_update", 7'h30, 7'h30, 7'h30);
    drive(4'd15, 4'd12, 4'd10);
    tick();
    check3("simultaneous_invalid", 7'h01, 7'h01, 7'h01);
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 16; i++) begin
      drive(i[3:0], 4'd0, 4'd8);
      tick();
      total_cnt++;
      if (seg_unidades !== (seg_tab[i] ^ INV) || seg_dezenas !== (7'h7E ^ INV) ||
          seg_minutos !== (7'h7F ^ INV))
        $display("FAIL sweep_unidades[%0d]: got %h/%h/%h expected %h/%h/%h", i,
                 seg_unidades, seg_dezenas, seg_minutos, seg_tab[i] ^ INV, 7'h7E ^ INV, 7'h7F ^ INV);
      else
        pass_cnt++;
    end
    for (int i = 0; i < 16; i++) begin
      drive(4'd8, i[3:0], 4'd0);
      tick();
      total_cnt++;
      if (seg_dezenas !== (seg_tab[i] ^ INV) || seg_unidades !== (7'h7F ^ INV) ||
          seg_minutos !== (7'h7E ^ INV))
        $display("FAIL sweep_dezenas[%0d]: got %h/%h/%h expected %h/%h/%h", i,
                 seg_unidades, seg_dezenas, seg_minutos, 7'h7F ^ INV, seg_tab[i] ^ INV, 7'h7E ^ INV);
      else
        pass_cnt++;
    end
    for (int i = 0; i < 16; i++) begin
      drive(4'd0, 4'd8, i[3:0]);
      tick();
      total_cnt++;
      if (seg_minutos !== (seg_tab[i] ^ INV) || seg_unidades !== (7'h7E ^ INV) ||
          seg_dezenas !== (7'h7F ^ INV))
        $display("FAIL sweep_minutos[%0d]: got %h/%h/%h expected %h/%h/%h", i,
                 seg_unidades, seg_dezenas, seg_minutos, 7'h7E ^ INV, 7'h7F ^ INV, seg_tab[i] ^ INV);
      else
        pass_cnt++;
    end
  endtask

  task automatic test_mid_reset();
    drive(4'd9, 4'd5, 4'd2);
    tick();
    check3("show_2_59", 7'h7B, 7'h5B, 7'h6D);
    rst = 1'b1;
    tick();
    check3("mid_reset_blank", 7'h00, 7'h00, 7'h00);
    rst = 1'b0;
    #2;
    check3("release_still_blank", 7'h00, 7'h00, 7'h00);
    tick();
    check3("release_restore", 7'h7B, 7'h5B, 7'h6D);
  endtask

  initial begin
    seg_tab[0]  = 7'h7E; seg_tab[1]  = 7'h30; seg_tab[2]  = 7'h6D; seg_tab[3]  = 7'h79;
    seg_tab[4]  = 7'h33; seg_tab[5]  = 7'h5B; seg_tab[6]  = 7'h5F; seg_tab[7]  = 7'h70;
    seg_tab[8]  = 7'h7F; seg_tab[9]  = 7'h7B;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'h01;
    test_reset();
    test_digits();
    test_latency();
    test_sweep();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
